// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - single-cycle ALU feeding an in-order result buffer
module alu_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [3:0]                   op,
    input  logic [XLEN-1:0]              arg0,
    input  logic [XLEN-1:0]              arg1,
    input  logic [REG_ADDR_W-1:0]        i_rd,
    output logic                         o_valid,
    output logic [XLEN-1:0]              res,
    output logic [REG_ADDR_W-1:0]        o_rd,
    output logic                         o_carry,
    output logic                         o_error,
    input  logic                         clear,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int SHW = $clog2(XLEN);
    // Buffer entry layout: {error, carry, rd, result}
    localparam int EW  = XLEN + REG_ADDR_W + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } op_e;

    logic [XLEN:0]     add_w;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              alu_carry;
    logic              alu_err;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [EW-1:0]     head;
    logic              push;
    logic              pop;

    // Carry out of ADD is the extra top bit of a one-bit-wider unsigned sum.
    assign add_w = {1'b0, arg0} + {1'b0, arg1};
    // Only the low log2(XLEN) bits of arg1 select the shift distance.
    assign shamt = arg1[SHW-1:0];

    // Combinational ALU; illegal codes produce a zero result tagged as error.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_w[XLEN-1:0];
                alu_carry = add_w[XLEN];
            end
            OP_SUB: begin
                alu_res   = arg0 - arg1;
                alu_carry = (arg0 < arg1);
            end
            OP_AND:  alu_res = arg0 & arg1;
            OP_OR:   alu_res = arg0 | arg1;
            OP_XOR:  alu_res = arg0 ^ arg1;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(arg0) < $signed(arg1))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (arg0 < arg1)};
            OP_SLL:  alu_res = arg0 << shamt;
            OP_SRL:  alu_res = arg0 >> shamt;
            OP_SRA:  alu_res = $signed(arg0) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

    // Handshakes: a pop frees a slot in the same cycle, so a full buffer
    // still accepts when the committer is draining. i_ready never looks at i_valid.
    assign o_valid = (count_q != '0);
    assign pop     = o_valid & clear;
    assign i_ready = (count_q < FULL_CNT) | pop;
    assign push    = i_valid & i_ready;
    assign busy    = o_valid;
    assign count   = count_q;

    // Head outputs are forced to zero whenever the buffer is empty.
    assign head    = o_valid ? mem_q[rd_ptr_q] : '0;
    assign res     = head[XLEN-1:0];
    assign o_rd    = head[XLEN +: REG_ADDR_W];
    assign o_carry = head[XLEN + REG_ADDR_W];
    assign o_error = head[XLEN + REG_ADDR_W + 1];

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset drops any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {alu_err, alu_carry, i_rd, alu_res};
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe
module tb_alu_pipe;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int D    = 4;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  rd;
        logic        c;
        logic        e;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        bit          has_exp;
        exp_t        x;
    } stim_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              i_ready;
    logic [3:0]        op;
    logic [XLEN-1:0]   arg0;
    logic [XLEN-1:0]   arg1;
    logic [RW-1:0]     i_rd;
    logic              o_valid;
    logic [XLEN-1:0]   res;
    logic [RW-1:0]     o_rd;
    logic              o_carry;
    logic              o_error;
    logic              clear;
    logic              busy;
    logic [2:0]        count;

    exp_t  sb[$];
    stim_t stim[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    model_cnt = 0;
    int    clr_mode = 0;

    alu_pipe #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .op(op), .arg0(arg0), .arg1(arg1), .i_rd(i_rd),
        .o_valid(o_valid), .res(res), .o_rd(o_rd), .o_carry(o_carry),
        .o_error(o_error), .clear(clear), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic exp_t ref_model(input logic [3:0] o, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        longint unsigned s;
        int sh;
        int signed sa;
        e.r = '0; e.c = 1'b0; e.e = 1'b0; e.rd = rd;
        sh = int'(b % 32);
        sa = a;
        case (o)
            4'd0: begin s = longint'({32'd0, a}) + longint'({32'd0, b}); e.r = s[31:0]; e.c = s[32]; end
            4'd1: begin e.r = a - b; e.c = (a < b); end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: e.r = (a < b) ? 32'd1 : 32'd0;
            4'd7: begin s = longint'({32'd0, a}) * (64'd1 << sh); e.r = s[31:0]; end
            4'd8: e.r = a / (32'd1 << sh);
            4'd9: e.r = sa >>> sh;
            default: e.e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd0;
            3: return 32'(unsigned'($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    task automatic enq(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit has, input exp_t x);
        stim_t s;
        s.op = o; s.a = a; s.b = b; s.rd = rd; s.has_exp = has; s.x = x;
        stim.push_back(s);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] rd, input logic c, input logic e);
        exp_t x;
        x.r = r; x.rd = rd; x.c = c; x.e = e;
        return x;
    endfunction

    // Driver: presents the head of the stimulus queue; records expectation on accept.
    always begin
        @(posedge clk);
        #1;
        if (stim.size() > 0 && (clr_mode != 2 || $urandom_range(0, 3) != 0)) begin
            i_valid = 1'b1;
            op      = stim[0].op;
            arg0    = stim[0].a;
            arg1    = stim[0].b;
            i_rd    = stim[0].rd;
        end else begin
            i_valid = 1'b0;
            op      = 4'($urandom);
            arg0    = $urandom;
            arg1    = $urandom;
            i_rd    = 5'($urandom);
        end
        clear = (clr_mode == 1) ? 1'b1 : (clr_mode == 2) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        if (!rst && i_valid && (model_cnt < D || (model_cnt > 0 && clear))) begin
            sb.push_back(stim[0].has_exp ? stim[0].x
                                         : ref_model(stim[0].op, stim[0].a, stim[0].b, stim[0].rd));
            void'(stim.pop_front());
        end
    end

    // Occupancy model advanced on each edge from the handshake rules.
    always @(posedge clk) begin
        if (rst) begin
            model_cnt = 0;
            sb.delete();
        end else begin
            model_cnt = model_cnt
                      + ((i_valid && (model_cnt < D || (model_cnt > 0 && clear))) ? 1 : 0)
                      - ((model_cnt > 0 && clear) ? 1 : 0);
        end
    end

    // Monitor: checks flow-control outputs every cycle and pops results on commit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("count", 64'(count), 64'(model_cnt));
            chk("o_valid", 64'(o_valid), 64'(model_cnt != 0));
            chk("busy", 64'(busy), 64'(model_cnt != 0));
            chk("i_ready", 64'(i_ready), 64'(model_cnt < D || (model_cnt > 0 && clear)));
            if (model_cnt == 0) begin
                chk("head_zero", 64'({res, o_rd, o_carry, o_error}), 64'd0);
            end
            if (model_cnt > 0 && clear) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("head", 64'({res, o_rd, o_carry, o_error}), 64'({e.r, e.rd, e.c, e.e}));
                end
            end
        end
    end

    task automatic wait_drain(input int limit);
        int t = 0;
        while ((stim.size() != 0 || model_cnt != 0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (t >= limit) chk("drain_timeout", 64'(t), 64'(limit - 1));
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0);
        rst = 1'b1; i_valid = 1'b0; clear = 1'b1; op = 4'd0;
        arg0 = '0; arg1 = '0; i_rd = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_head", 64'({res, o_rd, o_carry, o_error}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed operations with fixed expected values.
        clr_mode = 1;
        enq(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 1, mk(32'h0, 5'd3, 1'b1, 1'b0));
        enq(4'd1, 32'd5, 32'd7, 5'd4, 1, mk(32'hFFFF_FFFE, 5'd4, 1'b1, 1'b0));
        enq(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5, 1, mk(32'd1, 5'd5, 1'b0, 1'b0));
        enq(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd6, 1, mk(32'd0, 5'd6, 1'b0, 1'b0));
        enq(4'd9, 32'h8000_0000, 32'h24, 5'd7, 1, mk(32'hF800_0000, 5'd7, 1'b0, 1'b0));
        enq(4'd8, 32'h8000_0000, 32'h24, 5'd8, 1, mk(32'h0800_0000, 5'd8, 1'b0, 1'b0));
        enq(4'd12, 32'h1234, 32'h5678, 5'd9, 1, mk(32'd0, 5'd9, 1'b0, 1'b1));
        enq(4'd0, 32'd2, 32'd3, 5'd10, 1, mk(32'd5, 5'd10, 1'b0, 1'b0));
        wait_drain(100);

        // Fill to full with the fifth operation held, then accept and pop together.
        @(negedge clk);
        clr_mode = 0;
        for (int i = 0; i < 5; i++) enq(4'(i), rnd32(), rnd32(), 5'(i + 16), 0, z);
        repeat (8) @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(i_ready), 64'd0);
        clr_mode = 1;
        @(negedge clk);
        chk("full_pop_ready", 64'(i_ready), 64'd1);
        @(negedge clk);
        chk("full_swap_count", 64'(count), 64'd4);
        wait_drain(100);

        // Reset mid-stream with a concurrent issue and commit.
        @(negedge clk);
        clr_mode = 0;
        for (int i = 0; i < 3; i++) enq(4'd4, rnd32(), rnd32(), 5'(i + 24), 0, z);
        begin
            int t = 0;
            while (model_cnt != 3 && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) chk("fill3_timeout", 64'(t), 64'd0);
        end
        clr_mode = 1;
        enq(4'd0, 32'd100, 32'd23, 5'd30, 0, z);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        clr_mode = 0;
        @(negedge clk);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_valid", 64'(o_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(i_ready), 64'd1);
        clr_mode = 1;
        wait_drain(100);

        // Randomized traffic with random commit back-pressure.
        clr_mode = 2;
        for (int i = 0; i < 300; i++) begin
            enq(($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                rnd32(), rnd32(), 5'($urandom), 0, z);
        end
        begin
            int t = 0;
            while (stim.size() != 0 && t < 5000) begin @(negedge clk); t++; end
            if (t >= 5000) chk("random_timeout", 64'(t), 64'd0);
        end
        clr_mode = 1;
        wait_drain(100);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
